peripheral_screen_capture: RTL

Memory-mapped HUB75 capture peripheral: the receiving end of the LED-matrix panel interface driven by the screen peripheral. It samples the panel signals (shift clock, six colour bits, latch, blank, row address) and stores one selected row's 64 shifted pixel pairs in a local buffer. The CPU reads that buffer over the same cs/rd/wr/addr bus. It sits on the rv32i peripheral bus and serves as a loopback checker and bring-up aid for the screen output.

---
 rtl/peripheral_screen_capture_pkg.sv | 50 +++++
 rtl/peripheral_screen_capture_sync_edge.sv | 33 +++
 rtl/peripheral_screen_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/peripheral_screen_capture_pkg.sv
// Shared constants for the HUB75 capture peripheral:
// register offsets, FSM encoding and panel bundle layout.
package peripheral_screen_capture_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PIX      = 3'd1;
    localparam logic [2:0] REG_LATCHCNT = 3'd2;

    localparam int ROW_PIXELS = 64;
    localparam int PIX_W      = 6;
    localparam int ROW_W      = 5;
    localparam int CNT_W      = 7;

    // Pixel bit positions inside {B1,G1,R1,B0,G0,R0}
    localparam int PIX_R0 = 0;
    localparam int PIX_G0 = 1;
    localparam int PIX_B0 = 2;
    localparam int PIX_R1 = 3;
    localparam int PIX_G1 = 4;
    localparam int PIX_B1 = 5;

    // Synchronised panel bundle; edge-detected bits sit at the bottom
    localparam int BIT_CLK   = 0;
    localparam int BIT_LATCH = 1;
    localparam int PIX_LSB   = 2;
    localparam int BIT_BLANK = PIX_LSB + PIX_W;
    localparam int ROW_LSB   = BIT_BLANK + 1;
    localparam int PANEL_W   = ROW_LSB + ROW_W;
    localparam int EDGE_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    function automatic logic [31:0] make_status(
        input cap_state_t       st,
        input logic             done,
        input logic             overrun,
        input logic             blank,
        input logic [ROW_W-1:0] cap_row,
        input logic [CNT_W-1:0] count
    );
        return {9'b0, count, 3'b0, cap_row, 3'b0,
                blank, overrun, done, st};
    endfunction

endpackage

// File: rtl/peripheral_screen_capture_sync_edge.sv
// Two-flop synchroniser for the panel bundle, with rising-edge
// detection on the low EDGE_W bits via a third flop.
module screen_sync_edge #(
    parameter int W      = 8,
    parameter int EDGE_W = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_d,
    output logic [W-1:0]  o_q,
    output logic [EDGE_W-1:0] o_rise
);

    logic [W-1:0]      r_s1;
    logic [W-1:0]      r_s2;
    logic [EDGE_W-1:0] r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2[EDGE_W-1:0];
        end
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2[EDGE_W-1:0] & ~r_s3;

endmodule

// File: rtl/peripheral_screen_capture.sv
// HUB75 capture peripheral: records one selected panel row into a
// 64x6 buffer that the CPU reads back over the peripheral bus.
module peripheral_screen_capture
    import peripheral_screen_capture_pkg::*;
#(
    parameter int clk_freq = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_in,
    input  logic [4:2]  addr,
    output logic [31:0] d_out,
    input  logic        clk_screen,
    input  logic        R0,
    input  logic        G0,
    input  logic        B0,
    input  logic        R1,
    input  logic        G1,
    input  logic        B1,
    input  logic        blank,
    input  logic        latch,
    input  logic [4:0]  row
);

    logic [PANEL_W-1:0] w_panel;
    logic [PANEL_W-1:0] w_sync;
    logic [EDGE_W-1:0]  w_rise;
    logic [PIX_W-1:0]   w_pixel;
    logic [ROW_W-1:0]   w_row;
    logic               w_blank;
    logic               w_shift;
    logic               w_latch;

    assign w_panel = {row, blank, B1, G1, R1, B0, G0, R0,
                      latch, clk_screen};

    screen_sync_edge #(
        .W      (PANEL_W),
        .EDGE_W (EDGE_W)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (w_panel),
        .o_q    (w_sync),
        .o_rise (w_rise)
    );

    assign w_pixel = w_sync[PIX_LSB +: PIX_W];
    assign w_row   = w_sync[ROW_LSB +: ROW_W];
    assign w_blank = w_sync[BIT_BLANK];
    assign w_shift = w_rise[BIT_CLK];
    assign w_latch = w_rise[BIT_LATCH];

    cap_state_t         r_state;
    cap_state_t         w_next;
    logic               r_done;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_count;
    logic [ROW_W-1:0]   r_target;
    logic [ROW_W-1:0]   r_cap_row;
    logic [PIX_W-1:0]   r_index;
    logic [31:0]        r_latch_cnt;
    logic [PIX_W-1:0]   r_pix [ROW_PIXELS];

    logic w_ctrl_wr;
    logic w_arm;
    logic w_idx_wr;

    assign w_ctrl_wr = cs & wr & (addr == REG_CTRL);
    assign w_arm     = w_ctrl_wr & d_in[0];
    assign w_idx_wr  = cs & wr & (addr == REG_PIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    logic w_cap;
    logic w_store;
    logic w_over_set;
    logic w_match;
    logic w_restart;

    // CPU control writes mask panel edges for that cycle
    always_comb begin
        w_cap      = (r_state == ST_CAPTURE) & ~w_ctrl_wr;
        w_store    = w_cap & w_shift & ~r_count[CNT_W-1];
        w_over_set = w_cap & w_shift & r_count[CNT_W-1];
        w_match    = w_cap & w_latch & (w_row == r_target);
        w_restart  = (w_cap & w_latch & (w_row != r_target))
                   | ((r_state == ST_WAIT) & ~w_ctrl_wr & w_latch);
    end

    always_comb begin
        w_next = r_state;
        if (w_ctrl_wr) begin
            w_next = w_arm ? ST_WAIT : ST_IDLE;
        end else begin
            case (r_state)
                ST_WAIT:    if (w_latch) w_next = ST_CAPTURE;
                ST_CAPTURE: if (w_match) w_next = ST_DONE;
                default:    w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_count     <= '0;
            r_target    <= '0;
            r_cap_row   <= '0;
            r_index     <= '0;
            r_latch_cnt <= '0;
        end else begin
            if (w_ctrl_wr) r_target <= d_in[12:8];
            if (w_idx_wr)  r_index  <= d_in[5:0];
            if (w_latch)   r_latch_cnt <= r_latch_cnt + 32'd1;
            if (w_arm) begin
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
                r_count   <= '0;
            end
            if (w_store)    r_count   <= r_count + 7'd1;
            if (w_over_set) r_overrun <= 1'b1;
            // A latch is applied after any same-cycle shift
            if (w_restart)  r_count   <= '0;
            if (w_match) begin
                r_done    <= 1'b1;
                r_cap_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROW_PIXELS; i++) r_pix[i] <= '0;
        end else if (w_store) begin
            r_pix[r_count[PIX_W-1:0]] <= w_pixel;
        end
    end

    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (addr)
            REG_CTRL:     w_rdata = make_status(r_state, r_done,
                              r_overrun, w_blank, r_cap_row, r_count);
            REG_PIX:      w_rdata = {26'b0, r_pix[r_index]};
            REG_LATCHCNT: w_rdata = r_latch_cnt;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           d_out <= '0;
        else if (cs && rd) d_out <= w_rdata;
    end

endmodule
